// File: rtl/sram_mem_controller_if.sv
// MEM-stage side of the SRAM data-memory controller: request, store data,
// read result and the ready/addr_err handshake back to the pipeline.
interface sram_mem_controller_if;
  localparam int unsigned DATA_W = 32;

  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              addr_err;

  // Pipeline (MEM stage) drives the request
  modport master (
    output rd_en, wr_en, addr, wdata,
    input  rdata, ready, addr_err
  );

  // Controller answers with data and handshake
  modport slave (
    input  rd_en, wr_en, addr, wdata,
    output rdata, ready, addr_err
  );
endinterface

// File: rtl/sram_mem_controller.sv
// Sequences one 32-bit MEM-stage access as two 16-bit phases (low, then high)
// on an external asynchronous SRAM, freezing the pipeline via ready.
// Optional feature: define SRAM_CTRL_ADDR_CHECK_EN to reject out-of-range or
// misaligned addresses with a one-cycle addr_err pulse.
module sram_mem_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_mem_controller_if.slave        bus,
  inout  wire  [15:0]                 sram_dq,
  output logic [17:0]                 sram_addr,
  output logic                        sram_we_n
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 17;
  localparam int unsigned SA_W   = 18;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [SA_W-1:0]   sram_addr_q, sram_addr_d;
  logic              we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              addr_err_q, addr_err_d;

  logic              req_c;
  logic              reject_c;
  logic [WORD_W-1:0] req_word_c;

  assign req_c = bus.rd_en | bus.wr_en;

`ifdef SRAM_CTRL_ADDR_CHECK_EN
  logic [31:0] off_c;

  // Offset into the SRAM window plus the range/alignment screen
  assign off_c      = bus.addr - 32'(ADDR_BASE);
  assign reject_c   = (bus.addr < 32'(ADDR_BASE)) ||
                      (off_c >= 32'h0008_0000)     ||
                      (bus.addr[1:0] != 2'b00);
  assign req_word_c = WORD_W'(off_c >> 2);
`else
  // No screening: the offset simply wraps into the 17-bit word index
  assign reject_c   = 1'b0;
  assign req_word_c = WORD_W'((bus.addr - 32'(ADDR_BASE)) >> 2);
`endif

  // Next-state, phase counter, latched request and registered pin values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    sram_addr_d = sram_addr_q;
    addr_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          is_wr_d = bus.wr_en;
          wdata_d = bus.wdata;
          cnt_d   = '0;
          if (reject_c) begin
            state_d    = S_DONE;
            addr_err_d = 1'b1;
            if (!bus.wr_en) rdata_d = '0;
          end else begin
            state_d     = S_LOW;
            sram_addr_d = {req_word_c, 1'b0};
          end
        end
      end
      S_LOW, S_HIGH: begin
        if (cnt_q == CNT_TC) begin
          cnt_d = '0;
          if (!is_wr_q) begin
            if (state_q == S_LOW) rdata_d[15:0]  = sram_dq;
            else                  rdata_d[31:16] = sram_dq;
          end
          if (state_q == S_LOW) begin
            state_d        = S_HIGH;
            sram_addr_d[0] = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Drive data for the whole write phase; strobe drops except on the last cycle
    dq_oe_d = is_wr_d && ((state_d == S_LOW) || (state_d == S_HIGH));
    we_n_d  = !(dq_oe_d && (cnt_d != CNT_TC));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // ready drops in the same cycle a request appears in IDLE, so it is combinational
  assign bus.ready    = (state_q == S_DONE) || ((state_q == S_IDLE) && !req_c);
  assign bus.rdata    = rdata_q;
  assign bus.addr_err = addr_err_q;

  assign sram_addr = sram_addr_q;
  assign sram_we_n = we_n_q;
  assign sram_dq   = dq_oe_q ? (sram_addr_q[0] ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small asynchronous SRAM model.
module tb_sram_mem_controller;
  localparam int unsigned WAIT_CYCLES = 5;
  localparam int unsigned ADDR_BASE   = 1024;
  localparam int          BOUND       = 40;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;

  sram_mem_controller_if bus ();

  sram_mem_controller #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .ADDR_BASE   (ADDR_BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_dq   (sram_dq),
    .sram_addr (sram_addr),
    .sram_we_n (sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: write lands on the rising strobe, read is combinational
  logic [15:0] mem [0:255];
  logic        model_oe;
  logic        probe;

  assign sram_dq = model_oe ? (probe ? 16'h5A5A : mem[sram_addr[7:0]]) : 16'bz;

  always @(posedge sram_we_n) if (rst) mem[sram_addr[7:0]] <= sram_dq;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full access from request to the DONE cycle; called just after a rising edge
  task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                           output int stall, output int we_lo, output int we_hi,
                           output logic [15:0] dq_lo, output logic [15:0] dq_hi,
                           output logic [16:0] word, output logic [31:0] rd,
                           output logic err);
    int cyc;
    stall = 0; we_lo = 0; we_hi = 0; dq_lo = '0; dq_hi = '0;
    word = '0; rd = '0; err = 1'b0; cyc = 0;
    bus.wr_en = wr; bus.rd_en = !wr; bus.addr = a; bus.wdata = d;
    model_oe = !wr; probe = 1'b0;
    while (cyc < BOUND) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.addr  = 32'hFFFF_FFFC;
        bus.wdata = 32'h0BAD_0BAD;
      end
      if (!sram_we_n) begin
        word = sram_addr[17:1];
        if (sram_addr[0]) begin we_hi++; dq_hi = sram_dq; end
        else              begin we_lo++; dq_lo = sram_dq; end
      end
      if (bus.ready) begin
        rd  = bus.rdata;
        err = bus.addr_err;
        break;
      end
      stall++;
      cyc++;
    end
    check_eq("access_done", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; model_oe = 1'b0;
  endtask

  int          stall, we_lo, we_hi;
  logic [15:0] dq_lo, dq_hi;
  logic [16:0] word;
  logic [31:0] rd;
  logic        err;
  logic        found;
  logic [17:0] addr_before;

  initial begin
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_oe = 1'b0; probe = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Reset / idle state
    @(negedge clk);
    check_eq("rst_ready",    32'(bus.ready),    32'd1);
    check_eq("rst_we_n",     32'(sram_we_n),    32'd1);
    check_eq("rst_rdata",    bus.rdata,         32'd0);
    check_eq("rst_sram_addr",32'(sram_addr),    32'd0);
    check_eq("rst_addr_err", 32'(bus.addr_err), 32'd0);
    model_oe = 1'b1; probe = 1'b1;
    #1 check_eq("rst_dq_released", 32'(sram_dq), 32'h5A5A);
    model_oe = 1'b0; probe = 1'b0;

    // Write 0xDEADBEEF to 1028
    @(posedge clk); #1;
    do_access(1'b1, 32'd1028, 32'hDEAD_BEEF, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("wr1028_stall",  32'(stall), 32'd11);
    check_eq("wr1028_we_lo",  32'(we_lo), 32'd4);
    check_eq("wr1028_we_hi",  32'(we_hi), 32'd4);
    check_eq("wr1028_dq_lo",  32'(dq_lo), 32'h0000_BEEF);
    check_eq("wr1028_dq_hi",  32'(dq_hi), 32'h0000_DEAD);
    check_eq("wr1028_saddr",  32'({word, 1'b0}), 32'd2);
    check_eq("wr1028_err",    32'(err),   32'd0);
    check_eq("wr1028_rdata",  rd,         32'd0);

    // Read back 1028
    do_access(1'b0, 32'd1028, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("rd1028_stall",  32'(stall), 32'd11);
    check_eq("rd1028_no_we",  32'(we_lo + we_hi), 32'd0);
    check_eq("rd1028_rdata",  rd,         32'hDEAD_BEEF);

    // Back-to-back writes; rdata must not move
    do_access(1'b1, 32'd1024, 32'h1111_2222, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("wr1024_stall",  32'(stall), 32'd11);
    check_eq("wr1024_saddr",  32'({word, 1'b0}), 32'd0);
    check_eq("wr1024_keep_rdata", rd,     32'hDEAD_BEEF);
    do_access(1'b1, 32'd1032, 32'h3333_4444, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("wr1032_stall",  32'(stall), 32'd11);
    check_eq("wr1032_saddr",  32'({word, 1'b0}), 32'd4);
    check_eq("wr1032_dq_hi",  32'(dq_hi), 32'h0000_3333);

    // Back-to-back reads
    do_access(1'b0, 32'd1024, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("rd1024_stall",  32'(stall), 32'd11);
    check_eq("rd1024_rdata",  rd,         32'h1111_2222);
    do_access(1'b0, 32'd1032, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("rd1032_stall",  32'(stall), 32'd11);
    check_eq("rd1032_rdata",  rd,         32'h3333_4444);
    @(negedge clk);
    check_eq("rdata_hold",    bus.rdata,  32'h3333_4444);

    // Reset during the HIGH phase of a write
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.addr = 32'd1040; bus.wdata = 32'hCAFE_F00D;
    found = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (sram_addr[0] && !sram_we_n) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reached_high",  32'(found), 32'd1);
    rst = 1'b0; bus.wr_en = 1'b0;
    #1;
    check_eq("midrst_ready",  32'(bus.ready), 32'd1);
    check_eq("midrst_we_n",   32'(sram_we_n), 32'd1);
    check_eq("midrst_rdata",  bus.rdata,      32'd0);
    model_oe = 1'b1; probe = 1'b1;
    #1 check_eq("midrst_dq_released", 32'(sram_dq), 32'h5A5A);
    model_oe = 1'b0; probe = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'd1032, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("postrst_stall", 32'(stall), 32'd11);
    check_eq("postrst_rdata", rd,         32'h3333_4444);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
    // Rejected read below the SRAM window
    addr_before = sram_addr;
    do_access(1'b0, 32'd1000, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("rej_stall",     32'(stall), 32'd1);
    check_eq("rej_addr_err",  32'(err),   32'd1);
    check_eq("rej_rdata",     rd,         32'd0);
    check_eq("rej_saddr",     32'(sram_addr), 32'(addr_before));
`else
    // Without screening the same address is a normal (wrapped) read
    addr_before = sram_addr;
    do_access(1'b0, 32'd1000, 32'h0, stall, we_lo, we_hi, dq_lo, dq_hi, word, rd, err);
    check_eq("nochk_stall",   32'(stall), 32'd11);
    check_eq("nochk_addr_err",32'(err),   32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
